// File: rtl/util_swap_axis.sv
// util_swap_axis: AXI-Stream symbol/bit swapper with registered output and
// a one-entry skid buffer.
//   mode 0 : bypass
//   mode 1 : full symbol reverse
//   mode 2 : reverse symbols within each group of G_NUM
//   mode 3 : reverse the bits inside every symbol
// The swap mode is latched on the first beat of each packet and held until
// the tlast beat is accepted.
// Optional feature: define UTIL_SWAP_AXIS_CNT_EN to add the pkt_cnt output,
// a wrapping count of delivered tlast beats.
module util_swap_axis #(
  parameter int S_NUM = 4,
  parameter int B_NUM = 8,
  parameter int G_NUM = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [1:0]               mode,
  input  logic [S_NUM*B_NUM-1:0]   s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [S_NUM*B_NUM-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [1:0]               mode_active
`ifdef UTIL_SWAP_AXIS_CNT_EN
  ,
  output logic [31:0]              pkt_cnt
`endif
);

  localparam int DATA_W = S_NUM * B_NUM;

  // Reject geometries the group-reverse mapping cannot express.
  generate
    if (S_NUM < 1 || B_NUM < 1 || G_NUM < 1 || (S_NUM % G_NUM) != 0) begin : g_bad_cfg
      $error("util_swap_axis: S_NUM must be a positive multiple of G_NUM, B_NUM >= 1");
    end
  endgenerate

  // Output symbol i takes input symbol S_NUM-1-i.
  function automatic logic [DATA_W-1:0] rev_symbols(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < S_NUM; i++) begin
      r[i*B_NUM +: B_NUM] = d[(S_NUM-1-i)*B_NUM +: B_NUM];
    end
    return r;
  endfunction

  // Symbol order is mirrored inside each G_NUM-wide group only.
  function automatic logic [DATA_W-1:0] rev_groups(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < S_NUM; i++) begin
      src = (i / G_NUM) * G_NUM + (G_NUM - 1 - (i % G_NUM));
      r[i*B_NUM +: B_NUM] = d[src*B_NUM +: B_NUM];
    end
    return r;
  endfunction

  // Symbols stay in place; bit k of each symbol moves to bit B_NUM-1-k.
  function automatic logic [DATA_W-1:0] rev_bits(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < S_NUM; i++) begin
      for (int k = 0; k < B_NUM; k++) begin
        r[i*B_NUM + k] = d[i*B_NUM + B_NUM - 1 - k];
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] swap_beat(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (m)
      2'd1:    r = rev_symbols(d);
      2'd2:    r = rev_groups(d);
      2'd3:    r = rev_bits(d);
      default: r = d;
    endcase
    return r;
  endfunction

  // Packet framing state
  logic                 first_beat;
  logic [1:0]           mode_hold;

  // Input stage (combinational, p0)
  logic [1:0]           mode_p0;
  logic signed [DATA_W-1:0] data_p0;
  logic                 accept_p0;

  // Output register and skid register (p1)
  logic signed [DATA_W-1:0] out_data_p1;
  logic                 out_last_p1;
  logic                 vld_p1;
  logic signed [DATA_W-1:0] skid_data_p1;
  logic                 skid_last_p1;
  logic                 skid_vld_p1;
  logic                 rdy_p1;

  // Next-state control
  logic                 drain;
  logic                 load_out;
  logic                 load_skid;
  logic                 vld_next;
  logic                 skid_vld_next;

  // Pick the mode for the beat on the input and swap it before storage.
  always_comb begin
    mode_p0   = first_beat ? mode : mode_hold;
    data_p0   = swap_beat(mode_p0, s_axis_tdata);
    accept_p0 = s_axis_tvalid & rdy_p1;
  end

  // Decide where an accepted beat lands and whether the skid refills the output.
  always_comb begin
    drain         = ~vld_p1 | m_axis_tready;
    load_out      = drain & (skid_vld_p1 | accept_p0);
    load_skid     = accept_p0 & ~drain;
    vld_next      = drain ? (skid_vld_p1 | accept_p0) : 1'b1;
    skid_vld_next = skid_vld_p1 ? ~drain : load_skid;
  end

  // Occupancy flags and the registered input-ready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
    end else begin
      vld_p1      <= vld_next;
      skid_vld_p1 <= skid_vld_next;
      rdy_p1      <= ~skid_vld_next;
    end
  end

  // Output register: the skid entry always goes out before any newer beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else if (load_out) begin
      if (skid_vld_p1) begin
        out_data_p1 <= skid_data_p1;
        out_last_p1 <= skid_last_p1;
      end else begin
        out_data_p1 <= data_p0;
        out_last_p1 <= s_axis_tlast;
      end
    end
  end

  // Skid register catches a beat accepted while the output is stalled.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= data_p0;
      skid_last_p1 <= s_axis_tlast;
    end
  end

  // Latch the mode on the first beat of a packet; re-arm after tlast.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      first_beat <= 1'b1;
      mode_hold  <= 2'd0;
    end else if (accept_p0) begin
      first_beat <= s_axis_tlast;
      if (first_beat) begin
        mode_hold <= mode;
      end
    end
  end

`ifdef UTIL_SWAP_AXIS_CNT_EN
  logic [31:0] cnt;

  // Count delivered end-of-packet beats, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= 32'd0;
    end else if (vld_p1 && m_axis_tready && out_last_p1) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign pkt_cnt = cnt;
`endif

  assign s_axis_tready = rdy_p1;
  assign m_axis_tdata  = out_data_p1;
  assign m_axis_tlast  = out_last_p1;
  assign m_axis_tvalid = vld_p1;
  assign mode_active   = mode_hold;

endmodule

// File: tb/tb_util_swap_axis.sv
// Testbench for util_swap_axis (S_NUM=4, B_NUM=8, G_NUM=2): directed
// scenarios followed by randomized traffic, checked every cycle against a
// queue-based reference model. Honours UTIL_SWAP_AXIS_CNT_EN if defined.
module tb_util_swap_axis;

  logic        clk;
  logic        rstn;
  logic [1:0]  mode;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [1:0]  mode_active;
`ifdef UTIL_SWAP_AXIS_CNT_EN
  logic [31:0] pkt_cnt;
`endif

  util_swap_axis #(.S_NUM(4), .B_NUM(8), .G_NUM(2)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .mode          (mode),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .mode_active   (mode_active)
`ifdef UTIL_SWAP_AXIS_CNT_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference swap working on a byte array.
  function automatic logic [31:0] model_swap(input logic [1:0] m, input logic [31:0] d);
    logic [7:0] s [4];
    logic [7:0] o [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) s[i] = d[8*i +: 8];
    for (int i = 0; i < 4; i++) begin
      case (m)
        2'd0: o[i] = s[i];
        2'd1: o[i] = s[3-i];
        2'd2: o[i] = s[i ^ 1];
        default: begin
          t = s[i];
          o[i] = {<<{t}};
        end
      endcase
    end
    return {o[3], o[2], o[1], o[0]};
  endfunction

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       q[$];
  logic        m_first    = 1'b1;
  logic [1:0]  m_cur_mode = 2'd0;
  logic [1:0]  m_mode_act = 2'd0;
  logic [31:0] m_cnt      = 32'd0;
  logic        rst_q      = 1'b0;
  int          n_deliv    = 0;

  // Model and per-cycle compare, evaluated mid-cycle when everything is stable.
  initial begin
    beat_t       b;
    logic [1:0]  m;
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
        chk("rst_m_tdata",  m_axis_tdata,       32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_mode_act", 32'(mode_active),   32'd0);
`ifdef UTIL_SWAP_AXIS_CNT_EN
        chk("rst_pkt_cnt",  pkt_cnt,            32'd0);
`endif
      end else begin
        chk("m_tvalid", 32'(m_axis_tvalid), 32'(q.size() > 0));
        chk("s_tready", 32'(s_axis_tready), 32'(q.size() < 2));
        chk("mode_active", 32'(mode_active), 32'(m_mode_act));
        if (m_axis_tvalid && q.size() > 0) begin
          chk("m_tdata", m_axis_tdata, q[0].d);
          chk("m_tlast", 32'(m_axis_tlast), 32'(q[0].l));
        end
`ifdef UTIL_SWAP_AXIS_CNT_EN
        chk("pkt_cnt", pkt_cnt, m_cnt);
`endif
      end
      if (!rstn) begin
        q.delete();
        m_first    = 1'b1;
        m_mode_act = 2'd0;
        m_cur_mode = 2'd0;
        m_cnt      = 32'd0;
      end else begin
        if (m_axis_tvalid && m_axis_tready && q.size() > 0) begin
          if (q[0].l) m_cnt = m_cnt + 32'd1;
          void'(q.pop_front());
          n_deliv++;
        end
        if (s_axis_tvalid && s_axis_tready) begin
          m = m_first ? mode : m_cur_mode;
          if (m_first) m_cur_mode = mode;
          m_mode_act = m;
          b.d = model_swap(m, s_axis_tdata);
          b.l = s_axis_tlast;
          q.push_back(b);
          m_first = s_axis_tlast;
        end
      end
      rst_q = rstn;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Single-beat packet with both sides ready; output checked one cycle later.
  task automatic send_one(input logic [1:0] m, input logic [31:0] d,
                          input logic [31:0] exp, input string name);
    mode          = m;
    s_axis_tdata  = d;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    cyc();
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk({name, "_vld"},  32'(m_axis_tvalid), 32'd1);
    chk({name, "_data"}, m_axis_tdata,       exp);
    chk({name, "_last"}, 32'(m_axis_tlast),  32'd1);
    chk({name, "_mode"}, 32'(mode_active),   32'(m));
    cyc();
  endtask

  task automatic drain(input string name);
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 50 && q.size() > 0; i++) cyc();
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int   idx;
    int   c;
    int   d0;
    logic acc;
    logic seen_low;

    rstn          = 1'b0;
    mode          = 2'd0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    chk("model_m1", model_swap(2'd1, 32'h11223344), 32'h44332211);
    chk("model_m2", model_swap(2'd2, 32'h11223344), 32'h22114433);
    chk("model_m3", model_swap(2'd3, 32'h0180F00F), 32'h80010FF0);

    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    chk("ready_after_rst", 32'(s_axis_tready), 32'd1);

    m_axis_tready = 1'b1;
    send_one(2'd1, 32'h11223344, 32'h44332211, "m1_beat");
    send_one(2'd2, 32'h11223344, 32'h22114433, "m2_beat");
    send_one(2'd3, 32'h0180F00F, 32'h80010FF0, "m3_beat");

    // Mode changes mid-packet must not affect the packet.
    s_axis_tvalid = 1'b1;
    mode = 2'd1; s_axis_tdata = 32'h01020304; s_axis_tlast = 1'b0; cyc();
    mode = 2'd0; s_axis_tdata = 32'h05060708; cyc();
    s_axis_tdata = 32'h090A0B0C; s_axis_tlast = 1'b1; cyc();
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("pkt3_last_data", m_axis_tdata, 32'h0C0B0A09);
    chk("pkt3_mode_act",  32'(mode_active), 32'd1);
    cyc();
    send_one(2'd0, 32'hAABBCCDD, 32'hAABBCCDD, "pkt_after_bypass");

    // Continuous 8-beat stream with a 5-cycle output stall.
    d0 = n_deliv;
    idx = 0; c = 0; seen_low = 1'b0;
    mode = 2'd0;
    while (idx < 8 && c < 40) begin
      m_axis_tready = !(c >= 3 && c <= 7);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {4{8'(idx)}};
      s_axis_tlast  = (idx == 7);
      acc = s_axis_tready;
      cyc();
      if (!s_axis_tready) seen_low = 1'b1;
      if (acc) idx++;
      c++;
    end
    chk("stream_all_sent", 32'(idx), 32'd8);
    chk("stream_ready_fell", 32'(seen_low), 32'd1);
    drain("stream_drain");
    chk("stream_delivered", 32'(n_deliv - d0), 32'd8);

    // Reset in the middle of a 4-beat packet.
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    mode = 2'd2; s_axis_tlast = 1'b0;
    s_axis_tdata = 32'h11111111; cyc();
    s_axis_tdata = 32'h22222222; cyc();
    s_axis_tvalid = 1'b0;
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_vld", 32'(m_axis_tvalid), 32'd0);
    cyc();
`ifdef UTIL_SWAP_AXIS_CNT_EN
    chk("midrst_cnt", pkt_cnt, 32'd0);
`endif
    m_axis_tready = 1'b1;
    send_one(2'd3, 32'h0180F00F, 32'h80010FF0, "post_rst");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rstn          = ($urandom_range(0, 399) != 0);
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      s_axis_tdata  = $urandom;
      s_axis_tlast  = ($urandom_range(0, 3) == 0);
      mode          = 2'($urandom_range(0, 3));
      m_axis_tready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    rstn = 1'b1;
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus never completes.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/util_swap_axis.md
UTIL_SWAP_AXIS -- requirements
Module: util_swap_axis

Interface
REQ-001 The block SHALL have parameter S_NUM, default 4: number of symbols per beat, legal range >=1.
REQ-002 The block SHALL have parameter B_NUM, default 8: bits per symbol, legal range >=1.
REQ-003 The block SHALL have parameter G_NUM, default 2: symbols per group for group-reverse mode; S_NUM SHALL be a multiple of G_NUM, otherwise elaboration SHALL fail.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 mode  input  2  requested swap mode: 0 bypass, 1 full symbol reverse, 2 group reverse, 3 per-symbol bit reverse.
REQ-007 s_axis_tdata  input  S_NUM*B_NUM  input beat data.
REQ-008 s_axis_tvalid / s_axis_tlast  input  1 each  input handshake and end-of-packet flag.
REQ-009 s_axis_tready  output  1  input accept.
REQ-010 m_axis_tdata  output  S_NUM*B_NUM  swapped beat data.
REQ-011 m_axis_tvalid / m_axis_tlast  output  1 each  output handshake and end-of-packet flag.
REQ-012 m_axis_tready  input  1  output accept.
REQ-013 mode_active  output  2  mode applied to the packet currently being accepted.

Function
REQ-014 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both 1, and delivered when m_axis_tvalid and m_axis_tready are both 1.
REQ-015 Mode 0: output symbol i SHALL equal input symbol i.
REQ-016 Mode 1: output symbol i SHALL equal input symbol S_NUM-1-i.
REQ-017 Mode 2: within each group g of G_NUM symbols, output symbol g*G_NUM+j SHALL equal input symbol g*G_NUM+G_NUM-1-j.
REQ-018 Mode 3: symbol order SHALL be kept, and bit k of each symbol SHALL map to bit B_NUM-1-k.
REQ-019 mode SHALL be sampled only on the first beat of a packet, meaning the first accepted beat after reset or after an accepted tlast beat. The sampled value SHALL drive mode_active and SHALL be held until the tlast beat is accepted.
REQ-020 A mode change in the middle of a packet SHALL NOT affect that packet's remaining beats.
REQ-021 When the first beat of a packet is accepted, the swap SHALL use the mode input value in that same cycle, not the previous packet's mode.
REQ-022 tlast SHALL travel with its beat, unmodified.
REQ-023 Latency SHALL be exactly 1 cycle from acceptance to m_axis_tvalid=1 when the output register is empty or being drained.
REQ-024 Throughput SHALL be 1 beat per cycle while m_axis_tready=1.
REQ-025 The block SHALL use an output register plus a one-entry skid register (2 beats total storage).
REQ-026 s_axis_tready SHALL be driven from a register, equal to NOT(skid occupied).
REQ-027 When the output register is stalled and a beat is accepted, that beat SHALL go to the skid register, and s_axis_tready SHALL fall on the next cycle.
REQ-028 When the output register drains, the skid entry SHALL move to the output register before any new input, preserving order.
REQ-029 No beat SHALL be dropped or duplicated under any tvalid/tready pattern.
REQ-030 Once m_axis_tvalid=1, m_axis_tdata and m_axis_tlast SHALL stay stable until delivery.

Reset
REQ-031 While rstn=0: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, mode_active=0, skid empty, packet state set to "first beat".
REQ-032 s_axis_tready SHALL be 1 on the first cycle after rstn returns to 1.
REQ-033 Reset asserted mid-packet SHALL discard all stored beats. The next accepted beat SHALL be treated as the first beat of a new packet.

Configuration
REQ-034 With macro UTIL_SWAP_AXIS_CNT_EN defined, the block SHALL add output pkt_cnt[31:0]. pkt_cnt SHALL reset to 0 and increment by 1 on each delivered beat with m_axis_tlast=1, wrapping from 0xFFFFFFFF to 0.
REQ-035 Without UTIL_SWAP_AXIS_CNT_EN, the pkt_cnt port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (S_NUM=4, B_NUM=8, G_NUM=2)
REQ-036 mode=1, single beat 0x11223344 with tlast=1 and m_axis_tready=1 -> 0x44332211 with tlast=1, exactly 1 cycle after acceptance.
REQ-037 mode=2, beat 0x11223344 -> 0x22114433; mode=3, beat 0x0180F00F -> 0x80010FF0.
REQ-038 3-beat packet, mode=1 on beat 1, mode=0 from beat 2 on -> all 3 beats symbol-reversed, mode_active=1 throughout. The following packet is bypassed with mode_active=0.
REQ-039 Continuous 8-beat stream 0x00..0x07 (replicated per byte), m_axis_tready low for cycles 3-7 -> s_axis_tready low within 1 cycle of skid fill, all 8 beats delivered in order, none lost.
REQ-040 rstn pulsed low for 1 cycle after beat 2 of a 4-beat packet -> m_axis_tvalid=0 the next cycle. The next packet starts with mode re-sampled; with CNT_EN, pkt_cnt=0.
